// File: rtl/ad7606_ctrl_if.sv
// ============================================================================
// Module      : ad7606_ctrl_if
// Description : ADC pin bundle and sample-sink bus for the AD7606 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ad7606_ctrl_if;
    logic        start_i;
    logic [2:0]  os_i;
    logic [15:0] adc_db_i;
    logic        adc_busy_i;
    logic        adc_frstdata_i;
    logic        adc_convst_o;
    logic        adc_cs_o;
    logic        adc_rd_o;
    logic        adc_reset_o;
    logic [2:0]  adc_os_o;
    logic [15:0] sample_o;
    logic [2:0]  sample_ch_o;
    logic        sample_valid_o;
    logic        sample_last_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        input  start_i, os_i, adc_db_i, adc_busy_i, adc_frstdata_i,
        output adc_convst_o, adc_cs_o, adc_rd_o, adc_reset_o, adc_os_o,
               sample_o, sample_ch_o, sample_valid_o, sample_last_o,
               busy_o, err_o
    );

    modport slave (
        output start_i, os_i, adc_db_i, adc_busy_i, adc_frstdata_i,
        input  adc_convst_o, adc_cs_o, adc_rd_o, adc_reset_o, adc_os_o,
               sample_o, sample_ch_o, sample_valid_o, sample_last_o,
               busy_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/ad7606_ctrl.sv
// ============================================================================
// Module      : ad7606_ctrl
// Description : Conversion/readout sequencer for one AD7606 parallel ADC.
//               Optional FRSTDATA alignment check: AD7606_FRSTDATA_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad7606_ctrl #(
    parameter int NUM_CH   = 8,
    parameter int CONV_LO  = 2,
    parameter int RD_LO    = 3,
    parameter int RD_HI    = 2,
    parameter int RST_CYC  = 4,
    parameter int BUSY_TMO = 1023
) (
    input  wire logic        clk_i,
    input  wire logic        reset_i,
    ad7606_ctrl_if.master    bus
);

    localparam int c_tmax_a = (BUSY_TMO > RST_CYC) ? BUSY_TMO : RST_CYC;
    localparam int c_tmax_b = (CONV_LO > RD_LO) ? CONV_LO : RD_LO;
    localparam int c_tmax_c = (c_tmax_b > RD_HI) ? c_tmax_b : RD_HI;
    localparam int c_tmax   = (c_tmax_a > c_tmax_c) ? c_tmax_a : c_tmax_c;
    localparam int CW       = $clog2(c_tmax + 1);

    localparam logic [CW-1:0] c_rst_end  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] c_conv_end = CW'(CONV_LO - 1);
    localparam logic [CW-1:0] c_rdl_end  = CW'(RD_LO - 1);
    localparam logic [CW-1:0] c_rdh_end  = CW'(RD_HI - 1);
    localparam logic [CW-1:0] c_tmo      = CW'(BUSY_TMO);
    localparam logic [CW-1:0] c_cnt_max  = {CW{1'b1}};
    localparam logic [2:0]    c_last_ch  = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_ARST = 3'd0,
        S_IDLE = 3'd1,
        S_CONV = 3'd2,
        S_WBH  = 3'd3,
        S_WBL  = 3'd4,
        S_RDL  = 3'd5,
        S_RDH  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_ch;
    logic [1:0]  r_busy_sync;
    logic        r_convst, r_cs, r_rd, r_adc_reset, r_busy, r_err;
    logic        r_valid, r_last;
    logic [2:0]  r_os, r_sample_ch;
    logic [15:0] r_sample;
    logic        w_busy_s;
    logic [CW-1:0] w_cnt_inc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_busy_sync <= 2'b00;
        else         r_busy_sync <= {r_busy_sync[0], bus.adc_busy_i};
    end
    assign w_busy_s = r_busy_sync[1];

`ifdef AD7606_FRSTDATA_CHK_EN
    logic [1:0] r_frst_sync;
    logic       w_frst_s;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_frst_sync <= 2'b00;
        else         r_frst_sync <= {r_frst_sync[0], bus.adc_frstdata_i};
    end
    assign w_frst_s = r_frst_sync[1];
`endif

    // Timing counter saturates so a stuck state can never wrap into a false terminal count.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= S_ARST;
            r_cnt       <= '0;
            r_ch        <= 3'd0;
            r_convst    <= 1'b1;
            r_cs        <= 1'b1;
            r_rd        <= 1'b1;
            r_adc_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_os        <= 3'd0;
            r_sample    <= 16'd0;
            r_sample_ch <= 3'd0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                S_ARST: begin
                    if (r_cnt == c_rst_end) begin
                        r_adc_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_err    <= 1'b0;
                        r_os     <= bus.os_i;
                        r_convst <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (r_cnt == c_conv_end) begin
                        r_convst <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_WBH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WBH: begin
                    if (w_busy_s) begin
                        r_cnt   <= '0;
                        r_state <= S_WBL;
                    end else if (r_cnt == c_tmo) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WBL: begin
                    // The BUSY edge is tested first so it beats a coincident timeout.
                    if (!w_busy_s) begin
                        r_ch    <= 3'd0;
                        r_cs    <= 1'b0;
                        r_rd    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RDL;
                    end else if (r_cnt == c_tmo) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RDL: begin
                    if (r_cnt == c_rdl_end) begin
                        r_sample    <= bus.adc_db_i;
                        r_sample_ch <= r_ch;
                        r_valid     <= 1'b1;
                        r_last      <= (r_ch == c_last_ch);
                        r_rd        <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_RDH;
`ifdef AD7606_FRSTDATA_CHK_EN
                        if (w_frst_s != (r_ch == 3'd0)) r_err <= 1'b1;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RDH: begin
                    if (r_cnt == c_rdh_end) begin
                        r_cnt <= '0;
                        if (r_ch == c_last_ch) begin
                            r_cs    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ch    <= r_ch + 3'd1;
                            r_rd    <= 1'b0;
                            r_state <= S_RDL;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.adc_convst_o   = r_convst;
    assign bus.adc_cs_o       = r_cs;
    assign bus.adc_rd_o       = r_rd;
    assign bus.adc_reset_o    = r_adc_reset;
    assign bus.adc_os_o       = r_os;
    assign bus.sample_o       = r_sample;
    assign bus.sample_ch_o    = r_sample_ch;
    assign bus.sample_valid_o = r_valid;
    assign bus.sample_last_o  = r_last;
    assign bus.busy_o         = r_busy;
    assign bus.err_o          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ad7606_ctrl.sv
// ============================================================================
// Module      : tb_ad7606_ctrl
// Description : Directed/randomised bench for ad7606_ctrl with a behavioural ADC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ad7606_ctrl;
    localparam int NUM_CH   = 8;
    localparam int CONV_LO  = 2;
    localparam int RD_LO    = 3;
    localparam int RD_HI    = 2;
    localparam int RST_CYC  = 4;
    localparam int BUSY_TMO = 1023;
`ifdef AD7606_FRSTDATA_CHK_EN
    localparam logic FRST_CHK = 1'b1;
`else
    localparam logic FRST_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ad7606_ctrl_if bus ();

    ad7606_ctrl #(
        .NUM_CH(NUM_CH), .CONV_LO(CONV_LO), .RD_LO(RD_LO), .RD_HI(RD_HI),
        .RST_CYC(RST_CYC), .BUSY_TMO(BUSY_TMO)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    // Behavioural ADC: BUSY pulse after CONVST, DB = base + word index.
    logic        tb_start   = 1'b0;
    logic [2:0]  tb_os      = 3'd0;
    logic        tb_busy    = 1'b0;
    logic [15:0] tb_base    = 16'h1000;
    int          tb_busy_hi = 20;
    logic        tb_busy_en = 1'b1;
    logic        tb_frst_bad = 1'b0;
    int          model_ch   = 0;

    assign bus.start_i        = tb_start;
    assign bus.os_i           = tb_os;
    assign bus.adc_busy_i     = tb_busy;
    assign bus.adc_db_i       = 16'(tb_base + 16'(model_ch));
    assign bus.adc_frstdata_i = tb_frst_bad ? 1'b0 : (model_ch == 0);

    always @(negedge bus.adc_convst_o or posedge bus.adc_rd_o) begin
        if (!bus.adc_convst_o) model_ch = 0;
        else                   model_ch = model_ch + 1;
    end

    always begin
        @(negedge bus.adc_convst_o);
        if (tb_busy_en) begin
            repeat (2) @(posedge clk);
            #1 tb_busy = 1'b1;
            repeat (tb_busy_hi) @(posedge clk);
            #1 tb_busy = 1'b0;
        end
    end

    // Monitor: captured words and strobe run lengths.
    logic [15:0] s_data[$];
    logic [2:0]  s_ch[$];
    logic        s_last[$];
    int lo_q[$], hi_q[$], cl_q[$];
    int lo_run = 0, hi_run = 0, cl_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            lo_run = 0; hi_run = 0; cl_run = 0;
        end else begin
            if (bus.sample_valid_o) begin
                s_data.push_back(bus.sample_o);
                s_ch.push_back(bus.sample_ch_o);
                s_last.push_back(bus.sample_last_o);
            end
            if (!bus.adc_rd_o) begin
                lo_run++;
                if (hi_run > 0) hi_q.push_back(hi_run);
                hi_run = 0;
            end else begin
                if (lo_run > 0) lo_q.push_back(lo_run);
                lo_run = 0;
                if (!bus.adc_cs_o) hi_run++;
                else               hi_run = 0;
            end
            if (!bus.adc_convst_o) cl_run++;
            else begin
                if (cl_run > 0) cl_q.push_back(cl_run);
                cl_run = 0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int w_idx, lo_idx, hi_idx, cl_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        w_idx  = s_data.size();
        lo_idx = lo_q.size();
        hi_idx = hi_q.size();
        cl_idx = cl_q.size();
    endtask

    task automatic pulse_start();
        @(negedge clk) tb_start = 1'b1;
        @(negedge clk) tb_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy_o !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'd0, bus.busy_o}, 32'd0);
    endtask

    // Reference frame: NUM_CH words base+i, channel i, last only on the final one.
    task automatic check_frame(input logic [15:0] b);
        int n = s_data.size() - w_idx;
        chk("n_words", n, NUM_CH);
        for (int i = 0; i < NUM_CH && i < n; i++) begin
            chk("word_data", {16'd0, s_data[w_idx+i]}, {16'd0, 16'(b + 16'(i))});
            chk("word_ch",   {29'd0, s_ch[w_idx+i]}, i);
            chk("word_last", {31'd0, s_last[w_idx+i]}, (i == NUM_CH-1) ? 32'd1 : 32'd0);
        end
        chk("rd_lo_runs", lo_q.size() - lo_idx, NUM_CH);
        for (int i = lo_idx; i < lo_q.size(); i++) chk("rd_lo_len", lo_q[i], RD_LO);
        chk("rd_hi_runs", hi_q.size() - hi_idx, NUM_CH-1);
        for (int i = hi_idx; i < hi_q.size(); i++) chk("rd_hi_len", hi_q[i], RD_HI);
        chk("convst_runs", cl_q.size() - cl_idx, 1);
        if (cl_q.size() > cl_idx) chk("convst_len", cl_q[cl_idx], CONV_LO);
    endtask

    task automatic run_frame(input logic [15:0] b, input int bh, input logic [2:0] o,
                             input logic exp_err);
        tb_base = b; tb_busy_hi = bh; tb_os = o;
        mark();
        pulse_start();
        chk("os_latch", {29'd0, bus.adc_os_o}, {29'd0, o});
        wait_idle(1000);
        check_frame(b);
        chk("frame_err", {31'd0, bus.err_o}, {31'd0, exp_err});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_convst", {31'd0, bus.adc_convst_o}, 1);
        chk("rst_cs",     {31'd0, bus.adc_cs_o}, 1);
        chk("rst_rd",     {31'd0, bus.adc_rd_o}, 1);
        chk("rst_adcrst", {31'd0, bus.adc_reset_o}, 1);
        chk("rst_busy",   {31'd0, bus.busy_o}, 1);
        chk("rst_err",    {31'd0, bus.err_o}, 0);
        chk("rst_valid",  {31'd0, bus.sample_valid_o}, 0);
        chk("rst_sample", {16'd0, bus.sample_o}, 0);
        chk("rst_os",     {29'd0, bus.adc_os_o}, 0);

        rst = 1'b0;
        n = 0;
        while (bus.adc_reset_o === 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("arst_len", n, RST_CYC);
        chk("idle_busy", {31'd0, bus.busy_o}, 0);
        chk("idle_convst", {31'd0, bus.adc_convst_o}, 1);
        chk("idle_cs", {31'd0, bus.adc_cs_o}, 1);

        run_frame(16'h1000, 20, 3'd5, 1'b0);
        for (int k = 0; k < 3; k++)
            run_frame(16'($urandom_range(0, 65535)), $urandom_range(3, 40),
                      3'($urandom_range(0, 7)), 1'b0);

        // BUSY never rises: timeout error, no words.
        tb_busy_en = 1'b0;
        mark();
        pulse_start();
        n = 0;
        while (bus.err_o !== 1'b1 && n < 1300) begin @(negedge clk); n++; end
        chk("tmo_err", {31'd0, bus.err_o}, 1);
        chk("tmo_window", {31'd0, (n >= BUSY_TMO && n <= BUSY_TMO + CONV_LO + 6)}, 1);
        @(negedge clk);
        chk("tmo_idle", {31'd0, bus.busy_o}, 0);
        chk("tmo_nowords", s_data.size() - w_idx, 0);
        tb_busy_en = 1'b1;
        tb_base = 16'h2000; tb_busy_hi = 10;
        mark();
        pulse_start();
        chk("err_clear", {31'd0, bus.err_o}, 0);
        wait_idle(1000);
        check_frame(16'h2000);

        // Starts during WBL and RDL must be ignored.
        tb_base = 16'($urandom_range(0, 65535)); tb_busy_hi = 30;
        mark();
        pulse_start();
        n = 0;
        while (tb_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        pulse_start();
        n = 0;
        while (bus.adc_rd_o !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("rd_seen", {31'd0, bus.adc_rd_o}, 0);
        pulse_start();
        wait_idle(1000);
        check_frame(tb_base);
        repeat (10) @(negedge clk);
        chk("no_retrigger_busy", {31'd0, bus.busy_o}, 0);
        chk("no_retrigger_conv", cl_q.size() - cl_idx, 1);

        // Reset during the 4th word.
        tb_base = 16'h3000; tb_busy_hi = 8;
        mark();
        pulse_start();
        n = 0;
        while (!((s_data.size() - w_idx) == 3 && bus.adc_rd_o === 1'b0) && n < 300) begin
            @(negedge clk); n++;
        end
        chk("mid_read_reached", s_data.size() - w_idx, 3);
        #2 rst = 1'b1;
        #1;
        chk("mr_cs", {31'd0, bus.adc_cs_o}, 1);
        chk("mr_rd", {31'd0, bus.adc_rd_o}, 1);
        chk("mr_adcrst", {31'd0, bus.adc_reset_o}, 1);
        chk("mr_valid", {31'd0, bus.sample_valid_o}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (bus.adc_reset_o === 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("mr_arst_len", n, RST_CYC);
        repeat (5) @(negedge clk);
        chk("mr_nowords", s_data.size() - w_idx, 3);

        // FRSTDATA low on channel 0.
        tb_frst_bad = 1'b1;
        run_frame(16'h4000, 12, 3'd1, FRST_CHK);
        tb_frst_bad = 1'b0;
        run_frame(16'($urandom_range(0, 65535)), 15, 3'd7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
